n64_vmux: RTL and testbench

// - Transmit side of the N64 digital video bus: serialises parallel pixel words {sync,R,G,B}

---
 rtl/n64_vmux.sv | 135 +++++++++++++
 tb/tb_n64_vmux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/n64_vmux.sv
// Transmit side of the N64 digital video bus: buffers {sync,R,G,B} pixel words in a
// small FIFO and serialises each into a 4-word nDSYNC/D group (SYNC, RED, GREEN, BLUE).
//
// state | meaning
// IDLE  | bus quiet (nDSYNC=1, D=0); waits for en_i with FIFO non-empty
// SYNC  | sync word on the bus; head popped (or last sync repeated on underrun)
// RED   | red channel of the group register
// GREEN | green channel of the group register
// BLUE  | blue channel; en_i decides another group or IDLE
module n64_vmux #(
   parameter int color_width_i = 7,
   parameter int FIFO_DEPTH    = 4,
   parameter int LVL_W         = 3
) (
   input  logic                           VCLK,
   input  logic                           nRST,
   input  logic                           en_i,
   input  logic                           n15bit_mode_i,
   input  logic                           pix_valid_i,
   output logic                           pix_ready_o,
   input  logic [4+3*color_width_i-1:0]   pix_data_i,
   output logic                           nDSYNC_o,
   output logic [color_width_i-1:0]       D_o,
   output logic                           underrun_o,
   output logic [LVL_W-1:0]               fifo_level_o
);

   localparam int D_W   = color_width_i;
   localparam int PIX_W = 4 + 3*D_W;
   localparam int PTR_W = LVL_W - 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_RED,
      ST_GREEN,
      ST_BLUE
   } state_t;

   state_t             state, state_n;
   logic [PIX_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [LVL_W-1:0]   level;
   logic [PIX_W-1:0]   group, group_n, head;
   logic               mode_full, mode_full_n;
   logic [3:0]         last_sync, last_sync_n;
   logic               go_sync, push, pop, under;
   logic               nsync_n, under_out_n;
   logic [D_W-1:0]     d_n;

   function automatic logic [D_W-1:0] colour(input logic [D_W-1:0] c, input logic full);
      colour = full ? c : {c[D_W-1:2], 2'b00};
   endfunction

   assign pix_ready_o  = (level < DEPTH_L);
   assign fifo_level_o = level;
   assign push         = pix_valid_i && pix_ready_o;
   assign head         = mem[rd_ptr];

   always_comb begin
      state_n     = state;
      go_sync     = 1'b0;
      group_n     = group;
      mode_full_n = mode_full;
      last_sync_n = last_sync;
      nsync_n     = 1'b1;
      d_n         = '0;
      case (state)
         ST_IDLE:  if (en_i && level != '0) go_sync = 1'b1;
         ST_SYNC:  state_n = ST_RED;
         ST_RED:   state_n = ST_GREEN;
         ST_GREEN: state_n = ST_BLUE;
         ST_BLUE:  if (en_i) go_sync = 1'b1; else state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (go_sync) state_n = ST_SYNC;
      pop         = go_sync && (level != '0);
      under       = go_sync && (level == '0);
      under_out_n = under;

      // Underrun blanks the colour words but repeats the previous sync pattern.
      if (go_sync) begin
         mode_full_n = n15bit_mode_i;
         group_n     = pop ? head : '0;
      end
      if (pop) last_sync_n = head[PIX_W-1 -: 4];

      case (state_n)
         ST_SYNC: begin
            nsync_n = 1'b0;
            d_n     = {{(D_W-4){1'b0}}, (pop ? head[PIX_W-1 -: 4] : last_sync)};
         end
         ST_RED:   d_n = colour(group[3*D_W-1 -: D_W], mode_full);
         ST_GREEN: d_n = colour(group[2*D_W-1 -: D_W], mode_full);
         ST_BLUE:  d_n = colour(group[D_W-1:0], mode_full);
         default:  d_n = '0;
      endcase
   end

   always_ff @(posedge VCLK) begin
      if (push) mem[wr_ptr] <= pix_data_i;
   end

   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         group      <= '0;
         mode_full  <= 1'b1;
         last_sync  <= 4'hF;
         nDSYNC_o   <= 1'b1;
         D_o        <= '0;
         underrun_o <= 1'b0;
      end else begin
         state      <= state_n;
         group      <= group_n;
         mode_full  <= mode_full_n;
         last_sync  <= last_sync_n;
         nDSYNC_o   <= nsync_n;
         D_o        <= d_n;
         underrun_o <= under_out_n;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_n64_vmux.sv
// Directed bench for n64_vmux: reset, single pixel with underrun, back-to-back stream,
// 15-bit masking, enable drop and reset mid-group, all with hand-computed bus words.
module tb_n64_vmux;

   logic        VCLK = 1'b0;
   logic        nRST;
   logic        en_i;
   logic        n15bit_mode_i;
   logic        pix_valid_i;
   logic        pix_ready_o;
   logic [24:0] pix_data_i;
   logic        nDSYNC_o;
   logic [6:0]  D_o;
   logic        underrun_o;
   logic [2:0]  fifo_level_o;

   int checks   = 0;
   int failures = 0;

   n64_vmux dut (
      .VCLK          (VCLK),
      .nRST          (nRST),
      .en_i          (en_i),
      .n15bit_mode_i (n15bit_mode_i),
      .pix_valid_i   (pix_valid_i),
      .pix_ready_o   (pix_ready_o),
      .pix_data_i    (pix_data_i),
      .nDSYNC_o      (nDSYNC_o),
      .D_o           (D_o),
      .underrun_o    (underrun_o),
      .fifo_level_o  (fifo_level_o)
   );

   always #5 VCLK = ~VCLK;

   task automatic tick();
      @(posedge VCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic ns, input logic [6:0] d, input logic ur);
      chk({tag, ".nDSYNC"}, 32'(nDSYNC_o), 32'(ns));
      chk({tag, ".D"}, 32'(D_o), 32'(d));
      chk({tag, ".underrun"}, 32'(underrun_o), 32'(ur));
   endtask

   function automatic logic [24:0] word(input int k);
      logic [3:0] s;
      logic [6:0] r, g, b;
      s = 4'(k) ^ 4'h5;
      r = 7'h11 + 7'(k);
      g = 7'h23 + 7'(k);
      b = 7'h45 + 7'(k);
      return {s, r, g, b};
   endfunction

   initial begin
      int idx;
      logic acc;
      logic [24:0] w;

      // Reset held with valid data on the inputs.
      nRST = 1'b0; en_i = 1'b1; n15bit_mode_i = 1'b1;
      pix_valid_i = 1'b1; pix_data_i = {4'h1, 7'h12, 7'h34, 7'h56};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_bus("reset", 1'b1, 7'h00, 1'b0);
         chk("reset.level", 32'(fifo_level_o), 32'd0);
      end
      nRST = 1'b1; en_i = 1'b0; pix_valid_i = 1'b0;
      tick();
      chk("post_reset.level", 32'(fifo_level_o), 32'd0);

      // Single pixel then an underrun group.
      en_i = 1'b1; pix_valid_i = 1'b1; pix_data_i = {4'hB, 7'h55, 7'h2A, 7'h7F};
      tick();
      pix_valid_i = 1'b0;
      chk("single.level", 32'(fifo_level_o), 32'd1);
      chk_bus("single.idle", 1'b1, 7'h00, 1'b0);
      tick(); chk_bus("single.sync", 1'b0, 7'h0B, 1'b0);
      chk("single.level_pop", 32'(fifo_level_o), 32'd0);
      tick(); chk_bus("single.red", 1'b1, 7'h55, 1'b0);
      tick(); chk_bus("single.green", 1'b1, 7'h2A, 1'b0);
      tick(); chk_bus("single.blue", 1'b1, 7'h7F, 1'b0);
      tick(); chk_bus("under.sync", 1'b0, 7'h0B, 1'b1);
      tick(); chk_bus("under.red", 1'b1, 7'h00, 1'b0);
      tick(); chk_bus("under.green", 1'b1, 7'h00, 1'b0);
      tick(); chk_bus("under.blue", 1'b1, 7'h00, 1'b0);
      en_i = 1'b0;
      tick(); chk_bus("single.to_idle", 1'b1, 7'h00, 1'b0);

      // Back-to-back: fill the FIFO with en_i low, then stream 8 groups.
      pix_valid_i = 1'b1;
      for (idx = 0; idx < 4; idx++) begin
         pix_data_i = word(idx);
         chk("b2b.ready_fill", 32'(pix_ready_o), 32'd1);
         tick();
      end
      chk("b2b.level_full", 32'(fifo_level_o), 32'd4);
      chk("b2b.ready_full", 32'(pix_ready_o), 32'd0);
      chk_bus("b2b.idle_full", 1'b1, 7'h00, 1'b0);
      pix_data_i = word(idx);
      en_i = 1'b1;
      for (int c = 0; c < 32; c++) begin
         acc = pix_valid_i & pix_ready_o;
         tick();
         if (acc) begin
            idx++;
            if (idx < 8) pix_data_i = word(idx);
            else pix_valid_i = 1'b0;
         end
         w = word(c / 4);
         case (c % 4)
            0: chk_bus("b2b.sync", 1'b0, {3'b000, w[24:21]}, 1'b0);
            1: chk_bus("b2b.red", 1'b1, w[20:14], 1'b0);
            2: chk_bus("b2b.green", 1'b1, w[13:7], 1'b0);
            default: chk_bus("b2b.blue", 1'b1, w[6:0], 1'b0);
         endcase
         if (c == 31) en_i = 1'b0;
      end
      chk("b2b.all_pushed", 32'(idx), 32'd8);
      tick();
      chk_bus("b2b.idle", 1'b1, 7'h00, 1'b0);
      chk("b2b.level_end", 32'(fifo_level_o), 32'd0);

      // 15-bit mode latched at the sync edge, then changed mid-group.
      en_i = 1'b1; n15bit_mode_i = 1'b0;
      pix_valid_i = 1'b1; pix_data_i = {4'h3, 7'h7F, 7'h03, 7'h44};
      tick();
      pix_valid_i = 1'b0;
      tick(); chk_bus("m15.sync", 1'b0, 7'h03, 1'b0);
      n15bit_mode_i = 1'b1;
      tick(); chk_bus("m15.red", 1'b1, 7'h7C, 1'b0);
      tick(); chk_bus("m15.green", 1'b1, 7'h00, 1'b0);
      tick(); chk_bus("m15.blue", 1'b1, 7'h44, 1'b0);
      en_i = 1'b0;
      tick(); chk_bus("m15.idle", 1'b1, 7'h00, 1'b0);

      // Enable dropped during RED: group completes, FIFO retains remaining words.
      pix_valid_i = 1'b1;
      pix_data_i = {4'h6, 7'h01, 7'h02, 7'h03}; tick();
      pix_data_i = {4'h7, 7'h04, 7'h05, 7'h06}; tick();
      pix_data_i = {4'h8, 7'h07, 7'h08, 7'h09}; tick();
      pix_valid_i = 1'b0;
      chk("drop.level_fill", 32'(fifo_level_o), 32'd3);
      en_i = 1'b1;
      tick(); chk_bus("drop.sync", 1'b0, 7'h06, 1'b0);
      tick(); chk_bus("drop.red", 1'b1, 7'h01, 1'b0);
      en_i = 1'b0;
      tick(); chk_bus("drop.green", 1'b1, 7'h02, 1'b0);
      tick(); chk_bus("drop.blue", 1'b1, 7'h03, 1'b0);
      tick(); chk_bus("drop.idle", 1'b1, 7'h00, 1'b0);
      chk("drop.level_kept", 32'(fifo_level_o), 32'd2);

      // Reset in GREEN with level=2 abandons the group and flushes the FIFO.
      en_i = 1'b1; pix_valid_i = 1'b1; pix_data_i = {4'h9, 7'h0A, 7'h0B, 7'h0C};
      tick(); chk_bus("rmid.sync", 1'b0, 7'h07, 1'b0);
      pix_valid_i = 1'b0;
      tick(); chk_bus("rmid.red", 1'b1, 7'h04, 1'b0);
      tick(); chk_bus("rmid.green", 1'b1, 7'h05, 1'b0);
      chk("rmid.level", 32'(fifo_level_o), 32'd2);
      nRST = 1'b0;
      tick(); chk_bus("rmid.reset", 1'b1, 7'h00, 1'b0);
      chk("rmid.level_flush", 32'(fifo_level_o), 32'd0);
      nRST = 1'b1;
      tick(); chk_bus("rmid.after", 1'b1, 7'h00, 1'b0);
      chk("rmid.level_after", 32'(fifo_level_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
